// File: rtl/freq_bram_reader.sv
// Sweeps every bin of a single-port BRAM and streams each value out over a
// valid/ready handshake. Each bin takes FETCH -> CAPTURE -> SEND, so at least
// three cycles per bin, with back-pressure stretching SEND as needed.
module freq_bram_reader #(
    parameter int unsigned addr_w = 7,
    parameter int unsigned data_w = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic              r_en,
    output logic [addr_w-1:0] r_addr,
    input  logic [data_w-1:0] d_in,
    output logic [data_w-1:0] out_data,
    output logic [addr_w-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [addr_w-1:0] LastBin = '1;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StCapture,
        StSend
    } state_e;

    state_e              r_state;
    logic [addr_w-1:0]   r_cnt;
    logic                r_rd_en;
    logic [data_w-1:0]   r_out_data;
    logic [addr_w-1:0]   r_out_addr;
    logic                r_out_valid;
    logic                r_out_last;
    logic                r_busy;
    logic                r_done;

    logic                w_abort_active;
    logic                w_handshake;
    logic                w_at_last;

    // Abort only matters mid-sweep; in IDLE it just masks a same-cycle start.
    assign w_abort_active = abort && (r_state != StIdle);
    assign w_handshake    = r_out_valid && out_ready;
    assign w_at_last      = (r_cnt == LastBin);

    // Sweep sequencer with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_rd_en     <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort_active) begin
                // Abort wins over a handshake in the same cycle: the beat is dropped.
                r_state     <= StIdle;
                r_rd_en     <= 1'b0;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (start && !abort) begin
                            r_cnt   <= '0;
                            r_rd_en <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= StFetch;
                        end
                    end
                    StFetch: begin
                        r_rd_en <= 1'b0;
                        r_state <= StCapture;
                    end
                    StCapture: begin
                        // BRAM data for the fetched address is on d_in by this edge.
                        r_out_data  <= d_in;
                        r_out_addr  <= r_cnt;
                        r_out_valid <= 1'b1;
                        r_out_last  <= w_at_last;
                        r_state     <= StSend;
                    end
                    StSend: begin
                        if (w_handshake) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            if (w_at_last) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= StIdle;
                            end else begin
                                r_cnt   <= r_cnt + 1'b1;
                                r_rd_en <= 1'b1;
                                r_state <= StFetch;
                            end
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign r_en      = r_rd_en;
    assign r_addr    = r_cnt;
    assign out_data  = r_out_data;
    assign out_addr  = r_out_addr;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_freq_bram_reader.sv
// Bench for freq_bram_reader: BRAM model with a write port, a scoreboard of
// expected beats, a hold checker for stalled beats and a table of sweep scenarios.
module tb_freq_bram_reader;

    localparam int AW = 7;
    localparam int DW = 20;
    localparam int NB = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic          r_en;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] d_in;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] mem [NB];

    always #5 clk = ~clk;

    freq_bram_reader #(
        .addr_w (AW),
        .data_w (DW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .r_en      (r_en),
        .r_addr    (r_addr),
        .d_in      (d_in),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    // Synchronous BRAM: address sampled on the edge, data held while r_en is low.
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (r_en) d_in <= mem[r_addr];
    end

    int n_chk = 0;
    int n_fail = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } beat_t;

    beat_t q[$];
    beat_t exp_beat;
    beat_t held;
    logic  held_last;
    logic  stall_q = 1'b0;
    int    cyc = 0;
    int    beats = 0;
    int    dones = 0;
    int    start_cyc = 0;
    int    done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard, hold checker and start/done timestamps, sampled mid-cycle.
    always @(negedge clk) begin
        if (stall_q) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_addr", 32'(out_addr), 32'(held.a));
            chk("hold_data", 32'(out_data), 32'(held.d));
            chk("hold_last", 32'(out_last), 32'(held_last));
        end
        stall_q   = out_valid && !out_ready && !abort && reset_n;
        held      = '{a: out_addr, d: out_data};
        held_last = out_last;
        if (out_valid && out_ready && !abort && reset_n) begin
            beats++;
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL beat_extra: got bin %0d, expected no beat", out_addr);
            end else begin
                exp_beat = q.pop_front();
                chk("beat_addr", 32'(out_addr), 32'(exp_beat.a));
                chk("beat_data", 32'(out_data), 32'(exp_beat.d));
                chk("beat_last", 32'(out_last), 32'(exp_beat.a == AW'(NB - 1)));
            end
        end
        if (start && !busy && !abort && reset_n) start_cyc = cyc;
        if (done) begin
            dones++;
            done_cyc = cyc;
        end
    end

    typedef struct {
        int rnd;
        int restart_bin;
        int abort_bin;
        int reset_bin;
        int inv;
        int check_lat;
        int exp_beats;
        int exp_done;
    } vec_t;

    vec_t rows [8];

    task automatic load_mem(input int inv);
        for (int i = 0; i < NB; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = (inv != 0) ? DW'(NB - i) : DW'(i);
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_r_en"}, 32'(r_en), 32'd0);
        chk({tag, "_r_addr"}, 32'(r_addr), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_last"}, 32'(out_last), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
        chk({tag, "_out_addr"}, 32'(out_addr), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic run_row(input int r, input vec_t v);
        int b0;
        int d0;
        int k;
        bit fin;
        bit restarted;
        if (v.inv != 0) load_mem(1);
        b0 = beats;
        d0 = dones;
        for (int i = 0; i < v.exp_beats; i++)
            q.push_back('{a: AW'(i), d: (v.inv != 0) ? DW'(NB - i) : DW'(i)});
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        fin       = 1'b0;
        restarted = 1'b0;
        k         = 0;
        while (!fin && k < 4000) begin
            start     = 1'b0;
            abort     = 1'b0;
            out_ready = (v.rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (dones != d0) begin
                fin = 1'b1;
            end else if (out_valid && int'(out_addr) == v.restart_bin && !restarted) begin
                start     = 1'b1;
                restarted = 1'b1;
            end else if (out_valid && int'(out_addr) == v.abort_bin) begin
                abort     = 1'b1;
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                abort = 1'b0;
                chk($sformatf("r%0d_abort_valid", r), 32'(out_valid), 32'd0);
                chk($sformatf("r%0d_abort_busy", r), 32'(busy), 32'd0);
                chk($sformatf("r%0d_abort_r_en", r), 32'(r_en), 32'd0);
                fin = 1'b1;
            end else if (out_valid && int'(out_addr) == v.reset_bin) begin
                reset_n = 1'b0;
                #1;
                check_all_zero($sformatf("r%0d_rst", r));
                @(posedge clk);
                #1;
                reset_n = 1'b1;
                fin = 1'b1;
            end
            if (!fin) begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        chk($sformatf("r%0d_finished", r), 32'(fin), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        chk($sformatf("r%0d_beats", r), 32'(beats - b0), 32'(v.exp_beats));
        chk($sformatf("r%0d_dones", r), 32'(dones - d0), 32'(v.exp_done));
        chk($sformatf("r%0d_leftover", r), 32'(q.size()), 32'd0);
        q.delete();
        // start_cyc is taken in the cycle start is driven; the DUT samples it one edge later.
        if (v.check_lat != 0)
            chk($sformatf("r%0d_latency", r), 32'(done_cyc - start_cyc), 32'(3 * NB + 1));
    endtask

    initial begin
        int d0;
        //          rnd restart abort reset inv lat beats done
        rows[0] = '{0, -1, -1, -1, 0, 1, NB, 1};
        rows[1] = '{1, -1, -1, -1, 0, 0, NB, 1};
        rows[2] = '{0, 40, -1, -1, 0, 1, NB, 1};
        rows[3] = '{0, -1, 64, -1, 0, 0, 64, 0};
        rows[4] = '{0, -1, -1, -1, 0, 1, NB, 1};
        rows[5] = '{0, -1, -1, 100, 0, 0, 100, 0};
        rows[6] = '{0, -1, -1, -1, 0, 1, NB, 1};
        rows[7] = '{0, -1, -1, -1, 1, 1, NB, 1};

        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        load_mem(0);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // start and abort together in IDLE: nothing happens.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'd0);
        chk("sa_r_en", 32'(r_en), 32'd0);
        @(posedge clk);
        #1;
        chk("sa_busy_later", 32'(busy), 32'd0);

        // First bin timing with downstream stalled, then abort from SEND.
        d0    = dones;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("fetch_busy", 32'(busy), 32'd1);
        chk("fetch_r_en", 32'(r_en), 32'd1);
        chk("fetch_r_addr", 32'(r_addr), 32'd0);
        chk("fetch_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("capture_r_en", 32'(r_en), 32'd0);
        chk("capture_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("send_valid", 32'(out_valid), 32'd1);
        chk("send_addr", 32'(out_addr), 32'd0);
        chk("send_data", 32'(out_data), 32'd0);
        chk("send_last", 32'(out_last), 32'd0);
        chk("send_r_en", 32'(r_en), 32'd0);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("sabort_valid", 32'(out_valid), 32'd0);
        chk("sabort_busy", 32'(busy), 32'd0);
        chk("sabort_r_en", 32'(r_en), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("sabort_no_done", 32'(dones - d0), 32'd0);

        for (int r = 0; r < 8; r++) run_row(r, rows[r]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_bram_reader.md
FREQ_BRAM_READER -- requirements
Module: freq_bram_reader

Interface
REQ-001 The block SHALL have parameter addr_w, default 7, meaning the bin address width; number of bins = 2**addr_w.
REQ-002 The block SHALL have parameter data_w, default 20, meaning the bin data width.
REQ-003 The block SHALL have port clk  input  1  single clock for all logic.
REQ-004 The block SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port start  input  1  one-cycle request to begin a full bin sweep.
REQ-006 The block SHALL have port abort  input  1  terminate any sweep in progress.
REQ-007 The block SHALL have port r_en  output  1  BRAM read enable.
REQ-008 The block SHALL have port r_addr  output  addr_w  BRAM read address.
REQ-009 The block SHALL have port d_in  input  data_w  BRAM read data (BRAM d_out).
REQ-010 The block SHALL have port out_data  output  data_w  streamed bin value.
REQ-011 The block SHALL have port out_addr  output  addr_w  bin index of out_data.
REQ-012 The block SHALL have port out_valid  output  1  out_data/out_addr valid.
REQ-013 The block SHALL have port out_ready  input  1  downstream accepts when high with out_valid.
REQ-014 The block SHALL have port out_last  output  1  high with out_valid for bin 2**addr_w-1 only.
REQ-015 The block SHALL have ports busy and done, each output 1: sweep active; one-cycle completion pulse.

Function
REQ-016 BRAM model SHALL be: r_en/r_addr sampled at edge N, d_in valid after edge N+1 and held while r_en low.
REQ-017 FSM SHALL have states IDLE, FETCH, CAPTURE, SEND.
REQ-018 IDLE: start=1 SHALL load addr counter 0, go FETCH, busy=1 from next cycle.
REQ-019 FETCH: r_en=1, r_addr=counter for exactly one cycle; next state CAPTURE.
REQ-020 CAPTURE: r_en=0; at end of cycle, d_in -> out_data, counter -> out_addr; next SEND with out_valid=1.
REQ-021 SEND: out_valid, out_data, out_addr, out_last SHALL hold stable until out_valid&out_ready.
REQ-022 Handshake in SEND, counter != max: counter+1, go FETCH, out_valid=0 next cycle.
REQ-023 Handshake in SEND, counter = 2**addr_w-1: go IDLE, done=1 next cycle for one cycle, busy=0; counter SHALL NOT wrap into a second sweep.
REQ-024 Minimum throughput SHALL be one bin per 3 cycles; exactly 3*2**addr_w cycles start-to-done with out_ready tied high.
REQ-025 start while busy SHALL be ignored.
REQ-026 abort=1 in any non-IDLE state SHALL go IDLE next cycle, out_valid=0, r_en=0, no done pulse; abort has priority over a same-cycle handshake.
REQ-027 start and abort same cycle in IDLE: abort wins, stay IDLE.
REQ-028 r_addr SHALL equal counter at all times; r_en SHALL be high only in FETCH.

Reset
REQ-029 reset_n=0 SHALL asynchronously force IDLE, counter 0, r_en=0, r_addr=0, out_valid=0, out_last=0, out_data=0, out_addr=0, busy=0, done=0.
REQ-030 Reset mid-sweep SHALL discard the sweep; first start after release SHALL begin at bin 0.

Verification (BRAM preloaded mem[i]=i, addr_w=7)
REQ-031 start pulse, out_ready=1 -> 128 beats, out_addr=out_data=0..127 in order, out_last only on 127, done 384 cycles after start.
REQ-032 out_ready toggled pseudo-randomly -> same 128 beats, no value change while out_valid&!out_ready.
REQ-033 start asserted again at bin 40 -> ignored, sweep continues to 127 with single done.
REQ-034 abort at bin 64 in SEND with out_ready=1 -> beat 64 not accepted, IDLE next cycle, no done; new start sweeps from 0.
REQ-035 reset_n low at bin 100 -> all outputs 0 immediately, no done; restart yields 0..127.
REQ-036 Overwrite mem[i]=128-i via write port between sweeps -> second sweep returns 128-i.
